// File: rtl/cu_arbiter.sv
// cu_arbiter: shares one combinational control_unit (add/sub/signed mult/and on 4-bit operands)
// between two requesters. Round-robin arbitration in IDLE latches the winner's op and operands.
// EXEC drives the control unit for one cycle, and RESP holds the captured result under a
// valid/ready handshake, tagged with the requester id.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    requester N handshake (ready only in IDLE, one-hot)
//   reqN_op, reqN_a, reqN_b    op code (00 add, 01 sub, 10 signed mult, 11 and), operands
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     requester that issued the response
//   rsp_res                    {ResH, ResL} from the control unit
//   rsp_zero/rsp_ovf/rsp_cout  control unit flags
//   busy                       FSM not in IDLE
//   op_count                   completed response handshakes, wraps
module cu_arbiter #(
  parameter bit          PRIO_INIT = 1'b0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_res,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_cout,

  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpSub  = 2'b01;
  localparam logic [1:0] OpMult = 2'b10;
  localparam logic [1:0] OpAnd  = 2'b11;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;       // requester that wins a tie
  logic [1:0]       op_q, op_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_res_q, rsp_res_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // ---------------------------------------------------------------------------------------------
  // Control unit: purely combinational, driven from the latched op/operands.
  // ---------------------------------------------------------------------------------------------
  logic [4:0] add_full;
  logic [4:0] sub_full;
  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [7:0] prod;
  logic [3:0] cu_res_l;
  logic [3:0] cu_res_h;
  logic       cu_zero;
  logic       cu_ovf;
  logic       cu_cout;

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  // Bit 4 of the 5-bit difference is the borrow, which the unit reports as Cout.
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};
  // The low 8 bits of an unsigned product of sign-extended operands equal the signed product.
  assign a_ext    = {{4{a_q[3]}}, a_q};
  assign b_ext    = {{4{b_q[3]}}, b_q};
  assign prod     = a_ext * b_ext;

  always_comb begin
    cu_res_l = 4'h0;
    cu_res_h = 4'h0;
    cu_zero  = 1'b0;
    cu_ovf   = 1'b0;
    cu_cout  = 1'b0;
    unique case (op_q)
      OpAdd: begin
        cu_res_l = add_full[3:0];
        cu_cout  = add_full[4];
        cu_res_h = {4{add_full[4]}};
        cu_zero  = (add_full[3:0] == 4'h0);
        cu_ovf   = (a_q[3] == b_q[3]) && (add_full[3] != a_q[3]);
      end
      OpSub: begin
        cu_res_l = sub_full[3:0];
        cu_cout  = sub_full[4];
        cu_res_h = {4{sub_full[4]}};
        cu_zero  = (sub_full[3:0] == 4'h0);
        cu_ovf   = (a_q[3] != b_q[3]) && (sub_full[3] != a_q[3]);
      end
      OpMult: begin
        {cu_res_h, cu_res_l} = prod;
        cu_zero  = (prod == 8'h00);
        // Set when the product does not fit a 4-bit signed value.
        cu_ovf   = (prod[7:3] != 5'b00000) && (prod[7:3] != 5'b11111);
        cu_cout  = 1'b0;
      end
      OpAnd: begin
        cu_res_l = a_q & b_q;
        cu_res_h = 4'h0;
        cu_zero  = ((a_q & b_q) == 4'h0);
        cu_ovf   = 1'b0;
        cu_cout  = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Arbitration: a lone valid requester always wins; on a tie the pointer decides.
  // ---------------------------------------------------------------------------------------------
  logic gnt0;
  logic gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      gnt0 = req0_valid && (!req1_valid || (ptr_q == 1'b0));
      gnt1 = req1_valid && (!req0_valid || (ptr_q == 1'b1));
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // ---------------------------------------------------------------------------------------------
  // FSM next state and datapath
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_cout_d  = rsp_cout_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (gnt0) begin
          op_d    = req0_op;
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = 1'b0;
          ptr_d   = 1'b1;
          state_d = StExec;
        end else if (gnt1) begin
          op_d    = req1_op;
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = 1'b1;
          ptr_d   = 1'b0;
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_res_d   = {cu_res_h, cu_res_l};
        rsp_zero_d  = cu_zero;
        rsp_ovf_d   = cu_ovf;
        rsp_cout_d  = cu_cout;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        // Response data registers are left untouched so they keep their last values.
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= PRIO_INIT;
      op_q        <= 2'b00;
      a_q         <= 4'h0;
      b_q         <= 4'h0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= 8'h00;
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_cout_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_cout_q  <= rsp_cout_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q != StIdle);
  assign op_count  = op_count_q;

endmodule
